// File: rtl/iwls_verif_pkg.sv
// Shared types, default constants and MISR step function for the response
// checker and its signature register.
package iwls_verif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [15:0] DEF_POLY = 16'h1021;
  localparam logic [15:0] DEF_SEED = 16'hFFFF;

  // One MISR step on a register of 'width' bits (width in 1..63), carried in
  // 64-bit containers so any parameterised width can share this function.
  // Bits above 'width' in the result are always zero.
  function automatic logic [63:0] misr_step(
    input logic [63:0] sig,
    input logic [63:0] poly,
    input logic [63:0] din,
    input int unsigned width
  );
    logic [63:0] mask;
    logic [63:0] fb;
    mask = (64'd1 << width) - 64'd1;
    fb   = (((sig >> (width - 32'd1)) & 64'd1) != 64'd0) ? poly : 64'd0;
    return ((sig << 1) ^ fb ^ din) & mask;
  endfunction

endpackage

// File: rtl/response_misr.sv
// Multiple-input signature register: reloads SEED on load, otherwise folds
// din into the signature on every enabled cycle.
module response_misr
  import iwls_verif_pkg::*;
#(
  parameter int unsigned         SIG_W = 16,
  parameter logic [SIG_W-1:0]    POLY  = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0]    SEED  = SIG_W'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [SIG_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  logic [63:0] step_full;
  logic        unused_hi;

  assign step_full = misr_step(64'(sig), 64'(POLY), 64'(din), SIG_W);
  // Upper container bits are zero by construction; fold them away explicitly.
  assign unused_hi = ^step_full[63:SIG_W];

  // Signature register: load has priority over a data step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= step_full[SIG_W-1:0];
    end else begin
      sig <= sig;
    end
  end

endmodule

// File: rtl/response_checker.sv
// Response checker: compares each DUT output vector against its golden value,
// counts patterns and mismatches, latches the first failing index and
// compacts observed data into a MISR signature.
module response_checker
  import iwls_verif_pkg::*;
#(
  parameter int unsigned      OUT_W = 4,
  parameter int unsigned      PAT_W = 8,
  parameter int unsigned      SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             po_valid,
  input  logic [OUT_W-1:0] po,
  input  logic [OUT_W-1:0] exp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [PAT_W:0]   pat_count,
  output logic [PAT_W:0]   err_count,
  output logic             first_fail_valid,
  output logic [PAT_W-1:0] first_fail_idx,
  output logic [SIG_W-1:0] signature
);

  localparam logic [PAT_W:0] LAST_IDX = (PAT_W + 1)'((64'd1 << PAT_W) - 64'd1);

  state_t state;
  state_t next_state;

  logic accept;
  logic mismatch;
  logic last_sample;

  // A start pulse always wins: a sample arriving with start is discarded.
  assign accept      = (state == ST_RUN) && po_valid && !start;
  assign mismatch    = (po != exp);
  assign last_sample = accept && (pat_count == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: start (re)enters RUN from any state.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start) next_state = ST_RUN;
        else       next_state = ST_IDLE;
      end
      ST_RUN: begin
        if (start)            next_state = ST_RUN;
        else if (last_sample) next_state = ST_DONE;
        else                  next_state = ST_RUN;
      end
      ST_DONE: begin
        if (start) next_state = ST_RUN;
        else       next_state = ST_DONE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the state register and final error count.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    pass = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_RUN: begin
        busy = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
        pass = (err_count == {(PAT_W + 1){1'b0}});
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Pattern and error counters; cleared on start, frozen outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_count <= {(PAT_W + 1){1'b0}};
      err_count <= {(PAT_W + 1){1'b0}};
    end else if (start) begin
      pat_count <= {(PAT_W + 1){1'b0}};
      err_count <= {(PAT_W + 1){1'b0}};
    end else if (accept) begin
      pat_count <= pat_count + {{PAT_W{1'b0}}, 1'b1};
      err_count <= err_count + {{PAT_W{1'b0}}, mismatch};
    end else begin
      pat_count <= pat_count;
      err_count <= err_count;
    end
  end

  // First-fail latch: records the pre-increment pattern index once per run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_valid <= 1'b0;
      first_fail_idx   <= {PAT_W{1'b0}};
    end else if (start) begin
      first_fail_valid <= 1'b0;
      first_fail_idx   <= {PAT_W{1'b0}};
    end else if (accept && mismatch && !first_fail_valid) begin
      first_fail_valid <= 1'b1;
      first_fail_idx   <= pat_count[PAT_W-1:0];
    end else begin
      first_fail_valid <= first_fail_valid;
      first_fail_idx   <= first_fail_idx;
    end
  end

  response_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start),
    .en    (accept),
    .din   (SIG_W'(po)),
    .sig   (signature)
  );

endmodule

// File: tb/tb_response_checker.sv
// Directed testbench for response_checker (OUT_W=4, PAT_W=2, SEED=16'h0001).
module tb_response_checker;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        po_valid;
  logic [3:0]  po;
  logic [3:0]  exp;
  logic        busy;
  logic        done;
  logic        pass;
  logic [2:0]  pat_count;
  logic [2:0]  err_count;
  logic        first_fail_valid;
  logic [1:0]  first_fail_idx;
  logic [15:0] signature;

  int total;
  int bad;

  response_checker #(
    .OUT_W (4),
    .PAT_W (2),
    .SIG_W (16),
    .POLY  (16'h1021),
    .SEED  (16'h0001)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .po_valid         (po_valid),
    .po               (po),
    .exp              (exp),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .pat_count        (pat_count),
    .err_count        (err_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_idx   (first_fail_idx),
    .signature        (signature)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; registered outputs are read there too.
  task automatic send(input logic [3:0] p, input logic [3:0] e);
    @(negedge clk);
    start = 1'b0; po_valid = 1'b1; po = p; exp = e;
  endtask

  task automatic idle();
    @(negedge clk);
    start = 1'b0; po_valid = 1'b0; po = 4'h0; exp = 4'h0;
  endtask

  task automatic pulse_start(input logic v, input logic [3:0] p, input logic [3:0] e);
    @(negedge clk);
    start = 1'b1; po_valid = v; po = p; exp = e;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; po_valid = 1'b0; po = 4'h0; exp = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(4'hF, 4'h0);
    send(4'h5, 4'h5);
    idle();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b want=0", pass); end
    total++; if (pat_count !== 3'd0) begin bad++; $display("FAIL reset_pat got=%0d want=0", pat_count); end
    total++; if (err_count !== 3'd0) begin bad++; $display("FAIL reset_err got=%0d want=0", err_count); end
    total++; if (first_fail_valid !== 1'b0) begin bad++; $display("FAIL reset_ffv got=%b want=0", first_fail_valid); end
    total++; if (first_fail_idx !== 2'd0) begin bad++; $display("FAIL reset_ffi got=%0d want=0", first_fail_idx); end
    total++; if (signature !== 16'h0001) begin bad++; $display("FAIL reset_sig got=%h want=0001", signature); end
  endtask

  task automatic test_clean();
    pulse_start(1'b0, 4'h0, 4'h0);
    send(4'h0, 4'h0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL clean_busy_rise got=%b want=1", busy); end
    send(4'h0, 4'h0);
    send(4'h0, 4'h0);
    send(4'h0, 4'h0);
    idle();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL clean_done got=%b want=1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clean_busy_fall got=%b want=0", busy); end
    total++; if (pass !== 1'b1) begin bad++; $display("FAIL clean_pass got=%b want=1", pass); end
    total++; if (err_count !== 3'd0) begin bad++; $display("FAIL clean_err got=%0d want=0", err_count); end
    total++; if (pat_count !== 3'd4) begin bad++; $display("FAIL clean_pat got=%0d want=4", pat_count); end
    total++; if (signature !== 16'h0010) begin bad++; $display("FAIL clean_sig got=%h want=0010", signature); end
  endtask

  // po 3,5,A,F against exp 3,0,A,0: seed 1 -> 1 -> 7 -> 4 -> 7.
  task automatic test_mismatch();
    pulse_start(1'b0, 4'h0, 4'h0);
    send(4'h3, 4'h3);
    send(4'h5, 4'h0);
    send(4'hA, 4'hA);
    send(4'hF, 4'h0);
    idle();
    total++; if (err_count !== 3'd2) begin bad++; $display("FAIL mis_err got=%0d want=2", err_count); end
    total++; if (first_fail_idx !== 2'd1) begin bad++; $display("FAIL mis_ffi got=%0d want=1", first_fail_idx); end
    total++; if (first_fail_valid !== 1'b1) begin bad++; $display("FAIL mis_ffv got=%b want=1", first_fail_valid); end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL mis_pass got=%b want=0", pass); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL mis_done got=%b want=1", done); end
    total++; if (signature !== 16'h0007) begin bad++; $display("FAIL mis_sig got=%h want=0007", signature); end
  endtask

  task automatic test_gapped();
    pulse_start(1'b0, 4'h0, 4'h0);
    send(4'h3, 4'h3);
    idle(); idle();
    send(4'h5, 4'h0);
    idle();
    send(4'hA, 4'hA);
    idle(); idle(); idle();
    send(4'hF, 4'h0);
    idle();
    total++; if (err_count !== 3'd2) begin bad++; $display("FAIL gap_err got=%0d want=2", err_count); end
    total++; if (first_fail_idx !== 2'd1) begin bad++; $display("FAIL gap_ffi got=%0d want=1", first_fail_idx); end
    total++; if (signature !== 16'h0007) begin bad++; $display("FAIL gap_sig got=%h want=0007", signature); end
    send(4'hF, 4'h0);
    idle();
    total++; if (pat_count !== 3'd4) begin bad++; $display("FAIL gap_done_pat got=%0d want=4", pat_count); end
    total++; if (err_count !== 3'd2) begin bad++; $display("FAIL gap_done_err got=%0d want=2", err_count); end
    total++; if (signature !== 16'h0007) begin bad++; $display("FAIL gap_done_sig got=%h want=0007", signature); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL gap_done_hold got=%b want=1", done); end
  endtask

  task automatic test_restart();
    pulse_start(1'b0, 4'h0, 4'h0);
    send(4'h1, 4'h0);
    send(4'h2, 4'h2);
    // Restart with a simultaneous mismatching sample that must be dropped.
    pulse_start(1'b1, 4'hF, 4'h0);
    total++; if (pat_count !== 3'd2) begin bad++; $display("FAIL rst_mid_pat got=%0d want=2", pat_count); end
    total++; if (first_fail_valid !== 1'b1) begin bad++; $display("FAIL rst_mid_ffv got=%b want=1", first_fail_valid); end
    total++; if (first_fail_idx !== 2'd0) begin bad++; $display("FAIL rst_mid_ffi got=%0d want=0", first_fail_idx); end
    idle();
    total++; if (pat_count !== 3'd0) begin bad++; $display("FAIL restart_pat got=%0d want=0", pat_count); end
    total++; if (err_count !== 3'd0) begin bad++; $display("FAIL restart_err got=%0d want=0", err_count); end
    total++; if (first_fail_valid !== 1'b0) begin bad++; $display("FAIL restart_ffv got=%b want=0", first_fail_valid); end
    total++; if (signature !== 16'h0001) begin bad++; $display("FAIL restart_sig got=%h want=0001", signature); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL restart_busy got=%b want=1", busy); end
    for (int i = 0; i < 4; i++) send(4'h0, 4'h0);
    idle();
    total++; if (err_count !== 3'd0) begin bad++; $display("FAIL restart_end_err got=%0d want=0", err_count); end
    total++; if (pat_count !== 3'd4) begin bad++; $display("FAIL restart_end_pat got=%0d want=4", pat_count); end
    total++; if (signature !== 16'h0010) begin bad++; $display("FAIL restart_end_sig got=%h want=0010", signature); end
    total++; if (pass !== 1'b1) begin bad++; $display("FAIL restart_end_pass got=%b want=1", pass); end
  endtask

  task automatic test_async_reset();
    pulse_start(1'b0, 4'h0, 4'h0);
    send(4'h1, 4'h0);
    send(4'h6, 4'h6);
    @(negedge clk);
    start = 1'b0; po_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b want=0", busy); end
    total++; if (pat_count !== 3'd0) begin bad++; $display("FAIL arst_pat got=%0d want=0", pat_count); end
    total++; if (err_count !== 3'd0) begin bad++; $display("FAIL arst_err got=%0d want=0", err_count); end
    total++; if (first_fail_valid !== 1'b0) begin bad++; $display("FAIL arst_ffv got=%b want=0", first_fail_valid); end
    total++; if (signature !== 16'h0001) begin bad++; $display("FAIL arst_sig got=%h want=0001", signature); end
    #1 rst_n = 1'b1;
    pulse_start(1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) send(4'h0, 4'h0);
    idle();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL arst_run_done got=%b want=1", done); end
    total++; if (pat_count !== 3'd4) begin bad++; $display("FAIL arst_run_pat got=%0d want=4", pat_count); end
    total++; if (signature !== 16'h0010) begin bad++; $display("FAIL arst_run_sig got=%h want=0010", signature); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_clean();
    test_mismatch();
    test_gapped();
    test_restart();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/response_checker.md
# response_checker

Hardware response-side companion to the exhaustive stimulus counter that drives a synthesized benchmark netlist (`test_yig`-style `pi*`/`po*` ports). The block consumes one DUT output vector per applied pattern, together with the golden expected vector for that pattern. It compares the two and counts mismatches. It latches the index of the first failing pattern and compacts every observed vector into a MISR signature. It sits between the DUT `po*` bus and the bench/scoreboard, and replaces per-cycle result dumping with a pass/fail verdict and a signature.

## Interface
Parameters:
- `OUT_W`, 4: width of the DUT output vector (`po0..po{OUT_W-1}`); must be in 1..SIG_W.
- `PAT_W`, 8: stimulus counter width; a run is exactly 2^PAT_W patterns.
- `SIG_W`, 16: MISR width.
- `POLY`, 16'h1021: MISR feedback taps.
- `SEED`, 16'hFFFF: MISR value loaded on `start`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins or restarts a run.
- `po_valid`  in  1  the `po` and `exp` inputs hold one pattern's response this cycle.
- `po`  in  OUT_W  DUT output vector.
- `exp`  in  OUT_W  golden expected vector for the same pattern.
- `busy`  out  1  the block is in RUN.
- `done`  out  1  run complete; held until the next `start`.
- `pass`  out  1  valid when `done`=1; equals 1 iff `err_count`==0.
- `pat_count`  out  PAT_W+1  patterns consumed in the current run.
- `err_count`  out  PAT_W+1  mismatching patterns in the current run.
- `first_fail_valid`  out  1  at least one mismatch has been seen.
- `first_fail_idx`  out  PAT_W  pattern index of the first mismatch.
- `signature`  out  SIG_W  MISR state.

## Operation
- States are IDLE, RUN and DONE.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→DONE when the 2^PAT_W-th valid sample is consumed.
  - DONE→RUN on `start`.
  - `start` in RUN restarts the run.
- On every `start`:
  - `pat_count`, `err_count`, `first_fail_valid` and `first_fail_idx` are cleared.
  - `signature` is loaded with SEED.
  - `done` and `pass` go to 0.
  - If `po_valid` is asserted in the same cycle as `start`, that sample is discarded.
- In RUN, each cycle with `po_valid`=1:
  - `pat_count` increments by 1.
  - If `po`≠`exp`, `err_count` increments by 1.
  - On the first mismatch, `first_fail_idx` is set to `pat_count`[PAT_W-1:0] (the value before the increment) and `first_fail_valid` is set to 1. Later mismatches do not change either output.
  - `signature` updates as `{sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_ext(po)`.
- `po_valid` is ignored in IDLE and in DONE; all counters freeze.
- Width rules:
  - Counters are PAT_W+1 bits, so 2^PAT_W is representable and no saturation is needed.
  - `exp` does not affect the MISR; the signature covers observed data only.
- `pass` = (`err_count`==0). It is driven only while `done`=1 and is 0 otherwise.

## Timing
- Reset values:
  - State is IDLE.
  - `busy`, `done`, `pass`, `first_fail_valid`, `pat_count`, `err_count` and `first_fail_idx` are 0.
  - `signature` is SEED.
- Latency:
  - A sample accepted at edge N is reflected in all counters and in `signature` after edge N.
  - `busy` rises the cycle after `start`.
  - On the last sample, `done` and `pass` are valid after that same edge; `busy` falls at that edge.
- No back-pressure; one sample per cycle is accepted at full rate.
- `rst_n` asserted mid-run aborts immediately to reset values. Partial results are lost.

## Structure
- Shared package `iwls_verif_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_RUN`, `ST_DONE`);
  - the default `POLY` and `SEED` constants;
  - the MISR step as a function.
- Sub-module `response_misr` (SIG_W, POLY, SEED; ports `clk`, `rst_n`, `load`, `en`, `din`, `sig`) is natural. The top level holds the FSM, counters, comparator and first-fail latch.

## Test plan
All scenarios use OUT_W=4, PAT_W=2 (4 patterns), POLY=16'h1021.
- Reset: after reset, `start`=0 → all outputs 0 except `signature`=SEED; `po_valid` pulses are ignored.
- Clean run, SEED=16'h0001, 4 samples with `po`=`exp`=0 → `done`=1, `pass`=1, `err_count`=0, `pat_count`=4, `signature`=16'h0010.
- Mismatches: `po`≠`exp` on patterns 1 and 3 → `err_count`=2, `first_fail_idx`=1, `first_fail_valid`=1, `pass`=0.
- Gapped valid: samples separated by idle cycles, plus a `po_valid` asserted in DONE → same results as back-to-back; `pat_count` stays at 4.
- Restart: `start` after 2 samples, then 4 clean samples → `err_count`=0 and signature matches a fresh run; the earlier mismatch is cleared.
- Async reset: drop `rst_n` mid-run between edges → outputs return to reset values without waiting for a clock edge; a subsequent `start` runs normally.
